countdown_timer_p: RTL and testbench



---
 rtl/timer_pkg.sv | 19 +
 rtl/countdown_timer_p_if.sv | 36 +++
 rtl/tick_prescaler.sv | 28 ++
 rtl/countdown_timer_p.sv | 119 +++++++++++
 tb/tb_countdown_timer_p.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer family.
// State encoding, its width and the default prescale ratio.
package timer_pkg;

    localparam int STATE_W          = 2;
    localparam int DEFAULT_PRESCALE = 192;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    function automatic logic is_active(state_e s);
        return (s == RUN) || (s == PAUSED);
    endfunction

endpackage

// File: rtl/countdown_timer_p_if.sv
// Control/status bundle between a timer client and countdown_timer_p.
// Optional warn status exists only when CDT_WARN_EN is defined.
interface countdown_timer_p_if #(
    parameter int CNT_W = 10
);
    logic             start;
    logic             pause;
    logic             abort;
    logic             auto_reload;
    logic [CNT_W-1:0] load_value;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             expired;
    logic             expired_pulse;
    logic             tick;
`ifdef CDT_WARN_EN
    logic             warn;
`endif

    modport master (
        output start, pause, abort, auto_reload, load_value,
        input  count, busy, expired, expired_pulse, tick
`ifdef CDT_WARN_EN
        , input warn
`endif
    );

    modport slave (
        input  start, pause, abort, auto_reload, load_value,
        output count, busy, expired, expired_pulse, tick
`ifdef CDT_WARN_EN
        , output warn
`endif
    );

endinterface

// File: rtl/tick_prescaler.sv
// Divide-by-PRESCALE strobe: tick is combinational, high on the enabled cycle the counter wraps.
// No backpressure; clr restarts a full period, en low freezes the count.
module tick_prescaler #(
    parameter int PRESCALE = 192,
    parameter int PS_W     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [PS_W-1:0] PS_RELOAD = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            ps_q <= PS_RELOAD;
        end else if (en) begin
            ps_q <= (ps_q == '0) ? PS_RELOAD : ps_q - PS_W'(1);
        end
    end

    assign tick = en && (ps_q == '0);

endmodule

// File: rtl/countdown_timer_p.sv
// Countdown timer: one decrement per PRESCALE clocks, pause/abort/auto-reload; all outputs registered (1-cycle).
// No backpressure. Define CDT_WARN_EN to add WARN_LEVEL and the warn output.
module countdown_timer_p
    import timer_pkg::*;
#(
    parameter int CNT_W    = 10,
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int PS_W     = 16
`ifdef CDT_WARN_EN
    , parameter int WARN_LEVEL = 30
`endif
) (
    input logic                clk,
    input logic                reset,
    countdown_timer_p_if.slave bus
);

    state_e           state_q, state_nxt;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic [CNT_W-1:0] reload_q, reload_nxt;
    logic             pulse_q, pulse_nxt;
    logic             tick_q, tick_nxt;
    logic             ps_en, ps_clr, ps_tick;

    // PAUSED with pause released counts on that same edge, so no cycle is lost on resume.
    assign ps_en  = is_active(state_q) && !bus.pause && !bus.abort && !bus.start;
    assign ps_clr = bus.start || bus.abort;

    tick_prescaler #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (ps_clr),
        .en    (ps_en),
        .tick  (ps_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            pulse_q  <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            count_q  <= count_nxt;
            reload_q <= reload_nxt;
            pulse_q  <= pulse_nxt;
            tick_q   <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        count_nxt  = count_q;
        reload_nxt = reload_q;
        pulse_nxt  = 1'b0;
        tick_nxt   = 1'b0;
        if (bus.abort) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else if (bus.start) begin
            reload_nxt = bus.load_value;
            count_nxt  = bus.load_value;
            if (bus.load_value == '0) begin
                state_nxt = EXPIRED;
                pulse_nxt = 1'b1;
            end else begin
                state_nxt = RUN;
            end
        end else if (is_active(state_q)) begin
            if (bus.pause) begin
                state_nxt = PAUSED;
            end else begin
                state_nxt = RUN;
                if (ps_tick) begin
                    tick_nxt = 1'b1;
                    // Zero only survives in RUN after an auto-reload expiry; reload on this boundary.
                    if (count_q == '0) begin
                        count_nxt = reload_q;
                    end else begin
                        count_nxt = count_q - CNT_W'(1);
                        if (count_q == CNT_W'(1)) begin
                            pulse_nxt = 1'b1;
                            if (!bus.auto_reload) begin
                                state_nxt = EXPIRED;
                            end
                        end
                    end
                end
            end
        end
    end

    assign bus.count         = count_q;
    assign bus.busy          = is_active(state_q);
    assign bus.expired       = (state_q == EXPIRED);
    assign bus.expired_pulse = pulse_q;
    assign bus.tick          = tick_q;

`ifdef CDT_WARN_EN
    logic warn_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= is_active(state_nxt) && (count_nxt != '0) &&
                      (32'(count_nxt) <= WARN_LEVEL);
        end
    end

    assign bus.warn = warn_q;
`endif

endmodule

// File: tb/tb_countdown_timer_p.sv
// Bench for countdown_timer_p: vector table, directed multi-cycle sequences, then random traffic vs a reference model.
module tb_countdown_timer_p;

    localparam int CNT_W = 10;
    localparam int PS    = 4;
    localparam int WL    = 2;

    logic clk = 1'b0;
    logic reset;

    countdown_timer_p_if #(.CNT_W(CNT_W)) bus();

    countdown_timer_p #(
        .CNT_W    (CNT_W),
        .PRESCALE (PS),
        .PS_W     (16)
`ifdef CDT_WARN_EN
        , .WARN_LEVEL (WL)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit start, pause, abort, ar;
        int load;
        int e_count;
        bit e_busy, e_exp, e_pulse, e_tick;
    } vec_t;

    vec_t vecs[$];

    // Reference model: "clocks left until the next decrement" plus an active flag.
    int m_count  = 0;
    int m_left   = PS;
    int m_reload = 0;
    bit m_active = 0;
    bit m_exp    = 0;
    bit m_pulse  = 0;
    bit m_tick   = 0;

    task automatic add_n(input int n, input bit st, input bit pa, input bit ab, input bit ar,
                         input int ld, input int ec, input bit eb, input bit ee,
                         input bit ep, input bit et);
        vec_t v;
        v.start = st; v.pause = pa; v.abort = ab; v.ar = ar; v.load = ld;
        v.e_count = ec; v.e_busy = eb; v.e_exp = ee; v.e_pulse = ep; v.e_tick = et;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic model_step();
        m_pulse = 0;
        m_tick  = 0;
        if (reset) begin
            m_count = 0; m_left = PS; m_reload = 0; m_active = 0; m_exp = 0;
        end else if (bus.abort) begin
            m_active = 0; m_exp = 0; m_count = 0;
        end else if (bus.start) begin
            m_reload = int'(bus.load_value);
            m_count  = m_reload;
            m_left   = PS;
            if (m_reload == 0) begin
                m_active = 0; m_exp = 1; m_pulse = 1;
            end else begin
                m_active = 1; m_exp = 0;
            end
        end else if (m_active && !bus.pause) begin
            m_left--;
            if (m_left == 0) begin
                m_left = PS;
                m_tick = 1;
                if (m_count == 0) begin
                    m_count = m_reload;
                end else begin
                    m_count--;
                    if (m_count == 0) begin
                        m_pulse = 1;
                        if (!bus.auto_reload) begin
                            m_active = 0; m_exp = 1;
                        end
                    end
                end
            end
        end
    endtask

    function automatic bit model_warn(input int c, input bit b);
        return b && (c >= 1) && (c <= WL);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int ec, input bit eb, input bit ee,
                              input bit ep, input bit et);
        check({tag, ".count"},   32'(bus.count),         32'(ec));
        check({tag, ".busy"},    32'(bus.busy),          32'(eb));
        check({tag, ".expired"}, 32'(bus.expired),       32'(ee));
        check({tag, ".pulse"},   32'(bus.expired_pulse), 32'(ep));
        check({tag, ".tick"},    32'(bus.tick),          32'(et));
`ifdef CDT_WARN_EN
        check({tag, ".warn"},    32'(bus.warn),          32'(model_warn(ec, eb)));
`endif
    endtask

    task automatic drive(input bit st, input bit pa, input bit ab, input bit ar,
                         input int ld, input bit rs);
        reset           = rs;
        bus.start       = st;
        bus.pause       = pa;
        bus.abort       = ab;
        bus.auto_reload = ar;
        bus.load_value  = CNT_W'(ld);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n, input bit ar);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, ar, 0, 0);
            step();
        end
    endtask

    initial begin
        int ar_seq[6];
        int pulses;
        int hold_bad;
        bit pa;
        bit arr;

        // Load 3, one-shot: decrements at 4, 8, 12 clocks after start.
        add_n(1, 1, 0, 0, 0, 3,  3, 1, 0, 0, 0);
        add_n(3, 0, 0, 0, 0, 0,  3, 1, 0, 0, 0);
        add_n(1, 0, 0, 0, 0, 0,  2, 1, 0, 0, 1);
        add_n(3, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0);
        add_n(1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1);
        add_n(3, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
        add_n(1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1);
        add_n(2, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
        // Load 0: straight to EXPIRED with a single pulse, never busy.
        add_n(1, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0);
        add_n(2, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
        // Abort out of EXPIRED, then pause is ignored in IDLE.
        add_n(1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
        add_n(2, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0);

        drive(0, 0, 0, 0, 0, 1);
        step();
        step();
        check_outs("reset", 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].pause, vecs[i].abort, vecs[i].ar, vecs[i].load, 0);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_busy,
                       vecs[i].e_exp, vecs[i].e_pulse, vecs[i].e_tick);
        end

        // Pause for 7 clocks starting at clock 6 pushes the next decrement to clock 15.
        drive(1, 0, 0, 0, 5, 0);
        step();
        idle(5, 0);
        check("pause_pre.count", 32'(bus.count), 32'd4);
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            step();
        end
        check_outs("pause_frozen", 4, 1, 0, 0, 0);
        idle(2, 0);
        check("pause_e14.count", 32'(bus.count), 32'd4);
        idle(1, 0);
        check_outs("pause_e15", 3, 1, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 0);
        step();

        // Auto-reload, load 2: 2,1,0,2,1,0 one tick period each.
        ar_seq   = '{1, 0, 2, 1, 0, 2};
        pulses   = 0;
        hold_bad = 0;
        drive(1, 0, 0, 1, 2, 0);
        step();
        check("ar_start.count", 32'(bus.count), 32'd2);
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < PS; j++) begin
                drive(0, 0, 0, 1, 0, 0);
                step();
                pulses += int'(bus.expired_pulse);
                if (!bus.busy || bus.expired) hold_bad++;
            end
            check($sformatf("ar%0d.count", k), 32'(bus.count), 32'(ar_seq[k]));
            check($sformatf("ar%0d.pulse", k), 32'(bus.expired_pulse), 32'(ar_seq[k] == 0));
        end
        check("ar.pulses", 32'(pulses), 32'd2);
        check("ar.busy_held", 32'(hold_bad), 32'd0);

        // Abort beats start in the same cycle.
        drive(1, 0, 1, 0, 7, 0);
        step();
        check_outs("abort_start", 0, 0, 0, 0, 0);

        // Restart while running reloads count and restarts the prescaler.
        drive(1, 0, 0, 0, 5, 0);
        step();
        idle(2, 0);
        drive(1, 0, 0, 0, 9, 0);
        step();
        check_outs("restart", 9, 1, 0, 0, 0);
        idle(3, 0);
        check("restart_hold.count", 32'(bus.count), 32'd9);
        idle(1, 0);
        check_outs("restart_dec", 8, 1, 0, 0, 1);

        // Reset on the edge where a decrement 3->2 would have happened.
        drive(1, 0, 0, 0, 4, 0);
        step();
        idle(4, 0);
        check("rst_pre.count", 32'(bus.count), 32'd3);
        idle(3, 0);
        drive(0, 0, 0, 0, 0, 1);
        step();
        check_outs("reset_mid", 0, 0, 0, 0, 0);

        pa  = 0;
        arr = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 9) == 0) pa = !pa;
            if ($urandom_range(0, 29) == 0) arr = !arr;
            drive($urandom_range(0, 19) == 0, pa, $urandom_range(0, 79) == 0, arr,
                  int'($urandom_range(0, 5)), $urandom_range(0, 299) == 0);
            step();
            check_outs("rnd", m_count, m_active, m_exp, m_pulse, m_tick);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
